store_buffer: RTL and testbench
===============================

# store_buffer

Parametrised, depth-configurable store buffer for the TL/WB boundary of the datapath. Committed stores from WB are queued in FIFO order and drained one per handshake into the D-cache store port, decoupling store retirement from cache availability. Loads in TL probe the buffer combinationally for store-to-load forwarding, or are told to stall on a partial overlap. A drain/empty pair lets control logic quiesce memory before `iret` and `tlbwrite`.

## Interface
Parameters:
- `DEPTH`, 4, number of entries; power of two, ≥ 2
- `ADDR_W`, 20, physical address width (pptr_t width)
- `DATA_W`, 32, word width; must be 32 (4 byte lanes)

Ports:
- `clk`  in  1  clock; the block's only clock
- `rst`  in  1  reset; asynchronous, active-high
- `push_en`  in  1  commit a store this cycle
- `push_isbyte`  in  1  1 = byte store, 0 = word store
- `push_addr`  in  ADDR_W  physical store address
- `push_data`  in  DATA_W  store data; byte stores use bits [7:0]
- `full`  out  1  all DEPTH entries occupied
- `empty`  out  1  no entries occupied
- `count`  out  $clog2(DEPTH+1)  occupied entries
- `overflow`  out  1  sticky: a push was dropped
- `ld_en`  in  1  TL load probe valid
- `ld_isbyte`  in  1  probe is a byte load
- `ld_addr`  in  ADDR_W  probe physical address
- `ld_hit`  out  1  forwarding data valid
- `ld_conflict`  out  1  partial overlap; load must stall
- `ld_data`  out  DATA_W  forwarded data
- `store_en`  out  1  head entry valid toward D-cache
- `store_ready`  in  1  D-cache accepts head this cycle
- `store_isbyte`  out  1  head entry size
- `store_addr`  out  ADDR_W  head entry address
- `store_data`  out  DATA_W  head entry data

## Operation
- Storage: circular array of DEPTH entries {isbyte, addr, data}; `wr_ptr`, `rd_ptr` of $clog2(DEPTH) bits wrap modulo DEPTH; `count` is a separate register.
- Push: on posedge with `push_en` and (not full or pop this cycle), entry written at `wr_ptr`, `wr_ptr`+1.
- Pop: on posedge with `store_en && store_ready`, `rd_ptr`+1.
- Simultaneous push and pop: both occur; `count` unchanged. Allowed when full (pop frees the slot) and when count = 1.
- Push when full and no pop: dropped, state unchanged, `overflow` set and held until reset.
- Drain head: `store_en = !empty`; `store_isbyte/addr/data` driven from entry at `rd_ptr`. Outputs must stay stable while `store_en && !store_ready`.
- Forwarding (combinational, all valid entries): word match = `addr[ADDR_W-1:2]` equal; entry covers lanes 0–3 (word) or lane `addr[1:0]` (byte).
  - Select youngest valid entry whose lanes intersect the load's lanes (word load: 0–3; byte load: `ld_addr[1:0]`).
  - None: `ld_hit=0`, `ld_conflict=0`.
  - Youngest covers all requested lanes (word store; or byte store with same byte for a byte load): `ld_hit=1`. Word load returns entry data; byte load returns the lane byte zero-extended in [7:0].
  - Otherwise (word load vs youngest byte store): `ld_conflict=1`, `ld_hit=0`.
  - `ld_en=0`: `ld_hit=0`, `ld_conflict=0`, `ld_data=0`.
- Entry being popped in the same cycle still participates in forwarding; entry being pushed does not.

## Timing
- Reset (async, immediate): pointers and `count` = 0, `overflow` = 0, all entries invalid; `empty=1`, `full=0`, `store_en=0`, `store_*` = 0, `ld_hit=0`, `ld_conflict=0`, `ld_data=0`. Reset mid-drain discards all entries; no further store issued.
- Push → visible to forwarding and `count` one cycle later; earliest `store_en` one cycle after push into empty buffer.
- Pop → next head presented the following cycle; throughput 1 store/cycle with `store_ready` held high.
- Forwarding/conflict: zero-cycle combinational from `ld_*` and registered state.
- `full`, `empty`, `count` are registered-state functions, no combinational path from `push_en`/`store_ready`.

## Test plan
- Reset, push word 0x100/0xDEADBEEF, `store_ready=0` → `store_en=1`, `store_addr=0x100`, data stable 5 cycles; `store_ready=1` → popped, `empty=1` next cycle.
- Fill DEPTH=4 with `store_ready=0` → `full=1`, `count=4`; 5th push dropped, `overflow=1`; push+pop same cycle when full → `count` stays 4, order preserved across pointer wrap.
- Push word 0x200/0x11223344 then byte 0x202/0xAA; byte load 0x202 → `ld_hit`, `ld_data=0x000000AA`; byte load 0x201 → `ld_data=0x00000033` (lane 1); word load 0x200 → `ld_conflict=1`.
- Push word 0x300/0x1 then word 0x300/0x2 → word load 0x300 returns 0x2 (youngest); load 0x304 → no hit, no conflict.
- Assert `rst` mid-drain with 3 entries → all outputs reset immediately, `store_en` stays 0 after release.
- Continuous push and pop at 1/cycle for 20 cycles → `count` constant, D-cache sees addresses in push order.

Source files
------------

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - FIFO store buffer between WB and the D-cache store port
// Loads probe all queued stores combinationally for forwarding or a partial-overlap stall.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_en,
  input  logic                       push_isbyte,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic [DATA_W-1:0]          push_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  input  logic                       ld_en,
  input  logic                       ld_isbyte,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       ld_hit,
  output logic                       ld_conflict,
  output logic [DATA_W-1:0]          ld_data,
  output logic                       store_en,
  input  logic                       store_ready,
  output logic                       store_isbyte,
  output logic [ADDR_W-1:0]          store_addr,
  output logic [DATA_W-1:0]          store_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic              overflow_q;
  logic              ent_isbyte [DEPTH];
  logic [ADDR_W-1:0] ent_addr   [DEPTH];
  logic [DATA_W-1:0] ent_data   [DEPTH];

  logic pop;
  logic push_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign overflow = overflow_q;
  assign store_en = !empty;
  assign pop      = store_en && store_ready;
  // A pop in the same cycle frees the slot, so a full buffer can still accept.
  assign push_ok  = push_en && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop)
        count_q <= count_q + CW'(1);
      else if (!push_ok && pop)
        count_q <= count_q - CW'(1);
      if (push_en && !push_ok) overflow_q <= 1'b1;
    end
  end

  // Entry payload needs no reset: validity comes from rd_ptr/count_q alone.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      ent_isbyte[wr_ptr] <= push_isbyte;
      ent_addr[wr_ptr]   <= push_addr;
      ent_data[wr_ptr]   <= push_data;
    end
  end

  always_comb begin
    store_isbyte = 1'b0;
    store_addr   = '0;
    store_data   = '0;
    if (!empty) begin
      store_isbyte = ent_isbyte[rd_ptr];
      store_addr   = ent_addr[rd_ptr];
      store_data   = ent_data[rd_ptr];
    end
  end

  logic [3:0]        ld_lanes;
  logic [3:0]        e_lanes;
  logic [PW-1:0]     idx;
  logic              sel_found;
  logic              sel_cover;
  logic              sel_isbyte;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] sel_shift;

  // Walk oldest to youngest so the last intersecting entry wins.
  always_comb begin
    ld_lanes   = ld_isbyte ? (4'b0001 << ld_addr[1:0]) : 4'b1111;
    e_lanes    = '0;
    idx        = '0;
    sel_found  = 1'b0;
    sel_cover  = 1'b0;
    sel_isbyte = 1'b0;
    sel_data   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count_q) && (ent_addr[idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
        e_lanes = ent_isbyte[idx] ? (4'b0001 << ent_addr[idx][1:0]) : 4'b1111;
        if ((e_lanes & ld_lanes) != 4'b0000) begin
          sel_found  = 1'b1;
          sel_cover  = ((e_lanes & ld_lanes) == ld_lanes);
          sel_isbyte = ent_isbyte[idx];
          sel_data   = ent_data[idx];
        end
      end
    end
  end

  always_comb begin
    sel_shift   = sel_data >> {ld_addr[1:0], 3'b000};
    ld_hit      = ld_en && sel_found && sel_cover;
    ld_conflict = ld_en && sel_found && !sel_cover;
    ld_data     = '0;
    if (ld_hit) begin
      if (!ld_isbyte)
        ld_data = sel_data;
      else if (sel_isbyte)
        ld_data = {{(DATA_W-8){1'b0}}, sel_data[7:0]};
      else
        ld_data = {{(DATA_W-8){1'b0}}, sel_shift[7:0]};
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer
// Queue-based reference model plus forwarding vector table and directed corner sequences.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        push_en, push_isbyte;
  logic [19:0] push_addr;
  logic [31:0] push_data;
  logic        full, empty, overflow;
  logic [2:0]  count;
  logic        ld_en, ld_isbyte;
  logic [19:0] ld_addr;
  logic        ld_hit, ld_conflict;
  logic [31:0] ld_data;
  logic        store_en, store_ready, store_isbyte;
  logic [19:0] store_addr;
  logic [31:0] store_data;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(20), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .push_en(push_en), .push_isbyte(push_isbyte), .push_addr(push_addr), .push_data(push_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .ld_en(ld_en), .ld_isbyte(ld_isbyte), .ld_addr(ld_addr),
    .ld_hit(ld_hit), .ld_conflict(ld_conflict), .ld_data(ld_data),
    .store_en(store_en), .store_ready(store_ready), .store_isbyte(store_isbyte),
    .store_addr(store_addr), .store_data(store_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        isbyte;
    logic [19:0] addr;
    logic [31:0] data;
  } st_t;

  typedef struct {
    logic        en;
    logic        isbyte;
    logic [19:0] addr;
    logic        hit;
    logic        conflict;
    logic [31:0] data;
  } vec_t;

  st_t q[$];
  bit  m_ovf;
  int  n_chk;
  int  n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Youngest store touching any requested byte decides the outcome.
  function automatic void model_fwd(input logic isb, input logic [19:0] a,
                                    output logic hit, output logic conf, output logic [31:0] data);
    hit = 0; conf = 0; data = 0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].addr[19:2] == a[19:2]) begin
        if (!q[i].isbyte) begin
          hit  = 1;
          data = isb ? ((q[i].data >> (8 * a[1:0])) & 32'hFF) : q[i].data;
          return;
        end else if (!isb) begin
          conf = 1;
          return;
        end else if (q[i].addr[1:0] == a[1:0]) begin
          hit  = 1;
          data = q[i].data & 32'hFF;
          return;
        end
      end
    end
  endfunction

  task automatic check_all(input string tag);
    logic h, c;
    logic [31:0] d;
    st_t hd;
    model_fwd(ld_isbyte, ld_addr, h, c, d);
    if (!ld_en) begin h = 0; c = 0; d = 0; end
    hd = (q.size() != 0) ? q[0] : '0;
    chk({tag, ".count"}, count, q.size());
    chk({tag, ".empty"}, empty, q.size() == 0);
    chk({tag, ".full"}, full, q.size() == DEPTH);
    chk({tag, ".overflow"}, overflow, m_ovf);
    chk({tag, ".store_en"}, store_en, q.size() != 0);
    chk({tag, ".store_isbyte"}, store_isbyte, hd.isbyte);
    chk({tag, ".store_addr"}, store_addr, hd.addr);
    chk({tag, ".store_data"}, store_data, hd.data);
    chk({tag, ".ld_hit"}, ld_hit, h);
    chk({tag, ".ld_conflict"}, ld_conflict, c);
    chk({tag, ".ld_data"}, ld_data, d);
  endtask

  // Samples the inputs just before the edge, advances the model, returns at edge+1.
  task automatic model_clock();
    bit pop, pok;
    pop = (q.size() != 0) && store_ready;
    pok = push_en && ((q.size() < DEPTH) || pop);
    if (push_en && !pok) m_ovf = 1;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (pok) q.push_back({push_isbyte, push_addr, push_data});
    #1;
  endtask

  task automatic push1(input logic isb, input logic [19:0] a, input logic [31:0] d);
    push_en = 1; push_isbyte = isb; push_addr = a; push_data = d;
    model_clock();
    push_en = 0;
  endtask

  vec_t vt[10];

  initial begin
    n_chk = 0; n_fail = 0; m_ovf = 0;
    rst = 1; push_en = 0; push_isbyte = 0; push_addr = 0; push_data = 0;
    ld_en = 0; ld_isbyte = 0; ld_addr = 0; store_ready = 0;
    #1;
    chk("rst.empty", empty, 1);
    chk("rst.full", full, 0);
    chk("rst.count", count, 0);
    chk("rst.store_en", store_en, 0);
    chk("rst.store_addr", store_addr, 0);
    chk("rst.ld_hit", ld_hit, 0);
    #2 rst = 0;
    @(posedge clk); #1;

    // Single word held at the head while the cache stalls.
    push1(0, 20'h100, 32'hDEADBEEF);
    chk("hold.store_en", store_en, 1);
    chk("hold.store_addr", store_addr, 20'h100);
    for (int i = 0; i < 5; i++) begin
      model_clock();
      chk("hold.store_data", store_data, 32'hDEADBEEF);
      chk("hold.store_addr2", store_addr, 20'h100);
    end
    store_ready = 1;
    model_clock();
    store_ready = 0;
    chk("pop.empty", empty, 1);
    check_all("pop");

    // Fill, overflow, then push+pop while full across pointer wrap.
    for (int k = 1; k <= 4; k++) push1(0, 20'(k * 16), 32'(k));
    chk("fill.full", full, 1);
    chk("fill.count", count, 4);
    push1(0, 20'h0F0, 32'hBAD);
    chk("ovf.overflow", overflow, 1);
    chk("ovf.count", count, 4);
    push_en = 1; push_addr = 20'h050; push_data = 32'h5; store_ready = 1;
    model_clock();
    push_en = 0;
    chk("pp.count", count, 4);
    chk("pp.head", store_addr, 20'h020);
    for (int k = 2; k <= 5; k++) begin
      chk("wrap.order", store_addr, 20'(k * 16));
      check_all("wrap");
      model_clock();
    end
    store_ready = 0;
    chk("wrap.empty", empty, 1);

    // Forwarding vectors against a fixed buffer image.
    push1(0, 20'h200, 32'h11223344);
    push1(1, 20'h202, 32'h000000AA);
    push1(0, 20'h300, 32'h1);
    push1(0, 20'h300, 32'h2);
    vt[0] = '{1, 1, 20'h202, 1, 0, 32'h000000AA};
    vt[1] = '{1, 1, 20'h201, 1, 0, 32'h00000033};
    vt[2] = '{1, 0, 20'h200, 0, 1, 32'h0};
    vt[3] = '{1, 0, 20'h300, 1, 0, 32'h2};
    vt[4] = '{1, 0, 20'h304, 0, 0, 32'h0};
    vt[5] = '{1, 1, 20'h203, 1, 0, 32'h00000011};
    vt[6] = '{1, 1, 20'h200, 1, 0, 32'h00000044};
    vt[7] = '{1, 1, 20'h301, 1, 0, 32'h0};
    vt[8] = '{1, 0, 20'h202, 0, 1, 32'h0};
    vt[9] = '{0, 1, 20'h202, 0, 0, 32'h0};
    for (int i = 0; i < 10; i++) begin
      ld_en = vt[i].en; ld_isbyte = vt[i].isbyte; ld_addr = vt[i].addr;
      #1;
      chk($sformatf("fwd%0d.hit", i), ld_hit, vt[i].hit);
      chk($sformatf("fwd%0d.conflict", i), ld_conflict, vt[i].conflict);
      chk($sformatf("fwd%0d.data", i), ld_data, vt[i].data);
    end
    ld_en = 0;
    store_ready = 1;
    for (int i = 0; i < 4; i++) model_clock();
    store_ready = 0;
    check_all("fwd_drain");

    // Reset in the middle of a drain discards everything.
    for (int k = 0; k < 3; k++) push1(0, 20'(12'h700 + k * 4), 32'(k));
    store_ready = 1;
    model_clock();
    rst = 1;
    #1;
    q.delete(); m_ovf = 0;
    chk("mrst.store_en", store_en, 0);
    chk("mrst.count", count, 0);
    chk("mrst.overflow", overflow, 0);
    chk("mrst.store_addr", store_addr, 0);
    #2 rst = 0;
    for (int i = 0; i < 3; i++) begin
      model_clock();
      chk("mrst.after", store_en, 0);
    end
    store_ready = 0;

    // Streaming one push and one pop per cycle.
    push1(0, 20'h800, 32'h800);
    push1(0, 20'h804, 32'h804);
    push_en = 1; store_ready = 1; push_isbyte = 0;
    for (int i = 0; i < 20; i++) begin
      push_addr = 20'(12'h808 + i * 4); push_data = 32'(i);
      #1;
      chk("stream.count", count, 2);
      check_all("stream");
      model_clock();
    end
    push_en = 0;

    // Random traffic on a small address window to provoke matches.
    for (int i = 0; i < 400; i++) begin
      push_en     = ($urandom_range(0, 2) != 0);
      push_isbyte = $urandom_range(0, 1);
      push_addr   = 20'h400 + 20'($urandom_range(0, 3) * 4 + $urandom_range(0, 3));
      push_data   = $urandom;
      store_ready = ($urandom_range(0, 2) == 0);
      ld_en       = $urandom_range(0, 3) != 0;
      ld_isbyte   = $urandom_range(0, 1);
      ld_addr     = 20'h400 + 20'($urandom_range(0, 4) * 4 + $urandom_range(0, 3));
      #1;
      check_all("rand");
      model_clock();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
